// File: rtl/mem_wb_stage_module.sv
// MEM stage, MEM/WB pipeline register and write-back mux for loads, stores and ALU results.
// Latency: non-memory ops 1 edge to write-back; memory ops take k+1 frozen cycles plus 1 DONE cycle.
// Backpressure: freeze stalls upstream while a request is outstanding; mem_req holds until mem_ready.
module mem_wb_stage_module #(
  parameter int LEN_REGISTER    = 32,
  parameter int LEN_REG_ADDRESS = 4,
  parameter int MEM_ADDR_W      = 16,
  parameter int ADDR_OFFSET     = 1024,
  parameter int TIMEOUT         = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_enable_in,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic [LEN_REGISTER-1:0]    alu_result_in,
  input  logic [LEN_REGISTER-1:0]    val_rm_in,
  input  logic [LEN_REG_ADDRESS-1:0] dest_reg_in,
  input  logic                       mem_ready,
  input  logic [LEN_REGISTER-1:0]    mem_rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [MEM_ADDR_W-1:0]      mem_addr,
  output logic [LEN_REGISTER-1:0]    mem_wdata,
  output logic                       freeze,
  output logic                       mem_error,
  output logic                       reg_file_wb_en,
  output logic [LEN_REG_ADDRESS-1:0] reg_file_wb_address,
  output logic [LEN_REGISTER-1:0]    reg_file_wb_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [CW-1:0]               cnt_nxt;
  logic [MEM_ADDR_W-1:0]       addr_q;
  logic [LEN_REGISTER-1:0]     wdata_q;
  logic                        we_q;
  logic [LEN_REGISTER-1:0]     load_lat_q;
  logic                        err_q;
  logic                        memop;
  logic [MEM_ADDR_W-1:0]       word_addr;

  // MEM/WB pipeline register contents
  logic                        wb_en_q;
  logic [LEN_REG_ADDRESS-1:0]  dest_q;
  logic                        mem_read_q;
  logic [LEN_REGISTER-1:0]     alu_q;
  logic [LEN_REGISTER-1:0]     load_q;

  // A simultaneous read+write request is handled as a store.
  assign memop     = mem_read_in | mem_write_in;
  assign cnt_nxt   = cnt + 1'b1;
  // Byte address relative to the memory window, converted to a word index with modulo wrap.
  assign word_addr = MEM_ADDR_W'((alu_result_in - LEN_REGISTER'(ADDR_OFFSET)) >> 2);

  // Stall upstream from the cycle a memory op is seen until its access completes; forced low in reset.
  assign freeze = rst & (((state == IDLE) & memop) | (state == ACCESS));

  assign mem_req   = (state == ACCESS);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_error = err_q;

  // Access FSM: capture request, wait for ready or timeout, then release the pipeline for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      load_lat_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (memop) begin
            addr_q  <= word_addr;
            wdata_q <= val_rm_in;
            we_q    <= mem_write_in;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt_nxt;
          if (mem_ready) begin
            load_lat_q <= mem_rdata;
            state      <= DONE;
          end else if (cnt_nxt == CW'(TIMEOUT)) begin
            err_q      <= 1'b1;
            load_lat_q <= '0;
            state      <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // MEM/WB register: advance when not frozen, otherwise insert a bubble so each op writes back once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      dest_q     <= '0;
      mem_read_q <= 1'b0;
      alu_q      <= '0;
      load_q     <= '0;
    end else if (freeze) begin
      wb_en_q <= 1'b0;
    end else begin
      wb_en_q    <= wb_enable_in & ~mem_write_in;
      dest_q     <= dest_reg_in;
      mem_read_q <= mem_read_in & ~mem_write_in;
      alu_q      <= alu_result_in;
      load_q     <= load_lat_q;
    end
  end

  assign reg_file_wb_en      = wb_en_q;
  assign reg_file_wb_address = dest_q;
  assign reg_file_wb_data    = mem_read_q ? load_q : alu_q;

endmodule

// File: tb/tb_mem_wb_stage_module.sv
// Self-checking bench for mem_wb_stage_module with a write-back scoreboard and memory responder.
// Latency: responder asserts mem_ready on a programmable ACCESS cycle (0 = never).
// Backpressure: stimulus holds each op until freeze drops, then replaces it with a nop.
module tb_mem_wb_stage_module;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_enable_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_write_in = 1'b0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] val_rm_in = '0;
  logic [3:0]  dest_reg_in = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        freeze;
  logic        mem_error;
  logic        reg_file_wb_en;
  logic [3:0]  reg_file_wb_address;
  logic [31:0] reg_file_wb_data;

  always #5 clk = ~clk;

  mem_wb_stage_module #(
    .LEN_REGISTER(32), .LEN_REG_ADDRESS(4), .MEM_ADDR_W(16), .ADDR_OFFSET(1024), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_enable_in(wb_enable_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .alu_result_in(alu_result_in), .val_rm_in(val_rm_in), .dest_reg_in(dest_reg_in),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .freeze(freeze), .mem_error(mem_error),
    .reg_file_wb_en(reg_file_wb_en), .reg_file_wb_address(reg_file_wb_address),
    .reg_file_wb_data(reg_file_wb_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  typedef struct packed { logic [3:0] dest; logic [31:0] data; } wb_t;
  typedef struct packed { logic we; logic [15:0] addr; logic [31:0] wdata; } req_t;

  wb_t         wb_q[$];
  req_t        req_q[$];
  logic [31:0] rd_q[$];
  int          resp_lat = 1;
  int          acc_cnt = 0;
  req_t        cur_req;

  task automatic push_wb(input logic [3:0] d, input logic [31:0] v);
    wb_t e;
    e.dest = d; e.data = v;
    wb_q.push_back(e);
  endtask

  task automatic push_req(input logic we, input logic [15:0] a, input logic [31:0] wd);
    req_t e;
    e.we = we; e.addr = a; e.wdata = wd;
    req_q.push_back(e);
  endtask

  // Memory model: checks each request against the expected queue and answers after resp_lat cycles.
  always @(negedge clk) begin
    if (mem_req) begin
      acc_cnt++;
      if (acc_cnt == 1) begin
        cur_req.we = mem_we; cur_req.addr = mem_addr; cur_req.wdata = mem_wdata;
        if (req_q.size() == 0) begin
          check_val("req_unexpected", 32'd1, 32'd0);
        end else begin
          req_t e;
          e = req_q.pop_front();
          check_val("req_we", {31'b0, mem_we}, {31'b0, e.we});
          check_val("req_addr", {16'b0, mem_addr}, {16'b0, e.addr});
          check_val("req_wdata", mem_wdata, e.wdata);
        end
      end else begin
        check_val("req_stable", {15'b0, mem_we, mem_addr}, {15'b0, cur_req.we, cur_req.addr});
      end
      if (acc_cnt == resp_lat) begin
        mem_ready = 1'b1;
        mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
      end
    end else begin
      acc_cnt   = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
    end
  end

  // Write-back scoreboard: every register-file write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && reg_file_wb_en) begin
      if (wb_q.size() == 0) begin
        check_val("wb_unexpected", {28'b0, reg_file_wb_address}, 32'hFFFF_FFFF);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check_val("wb_addr", {28'b0, reg_file_wb_address}, {28'b0, e.dest});
        check_val("wb_data", reg_file_wb_data, e.data);
      end
    end
  end

  task automatic drive(input logic wb, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dst);
    wb_enable_in = wb; mem_read_in = rd; mem_write_in = wr;
    alu_result_in = alu; val_rm_in = rm; dest_reg_in = dst;
  endtask

  // Presents an op (caller sits just after a rising edge), holds it until accepted, then drives a nop.
  task automatic send(input logic wb, input logic rd, input logic wr,
                      input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dst,
                      output int frz);
    int n;
    drive(wb, rd, wr, alu, rm, dst);
    frz = 0;
    n = 0;
    forever begin
      @(negedge clk);
      if (!freeze) break;
      frz++;
      n++;
      if (n > 60) begin
        check_val("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  int f;

  initial begin
    // Reset state
    #1;
    check_val("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_val("rst_freeze", {31'b0, freeze}, 32'd0);
    check_val("rst_wb_en", {31'b0, reg_file_wb_en}, 32'd0);
    check_val("rst_mem_error", {31'b0, mem_error}, 32'd0);
    check_val("rst_wb_data", reg_file_wb_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Reset dropped in the middle of an access
    @(posedge clk); #1;
    resp_lat = 0;
    push_req(1'b0, 16'd2, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd5);
    repeat (3) @(posedge clk);
    #2;
    check_val("t1_in_access", {31'b0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check_val("t1_req_async", {31'b0, mem_req}, 32'd0);
    check_val("t1_freeze_async", {31'b0, freeze}, 32'd0);
    check_val("t1_wb_en_async", {31'b0, reg_file_wb_en}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_val("t1_no_reissue", {31'b0, mem_req}, 32'd0);
    check_val("t1_no_error", {31'b0, mem_error}, 32'd0);

    // ALU op: written on the next edge, no stall
    push_wb(4'd3, 32'h55);
    send(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3, f);
    check_val("t2_freeze_cycles", f, 32'd0);
    check_val("t2_wb_en", {31'b0, reg_file_wb_en}, 32'd1);
    check_val("t2_wb_addr", {28'b0, reg_file_wb_address}, 32'd3);
    check_val("t2_wb_data", reg_file_wb_data, 32'h55);

    // Load with ready on the third ACCESS cycle
    resp_lat = 3;
    push_req(1'b0, 16'd2, 32'h0);
    rd_q.push_back(32'hDEAD_BEEF);
    push_wb(4'd5, 32'hDEAD_BEEF);
    send(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd5, f);
    check_val("t3_freeze_cycles", f, 32'd4);
    check_val("t3_wb_en", {31'b0, reg_file_wb_en}, 32'd1);
    check_val("t3_wb_data", reg_file_wb_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check_val("t3_written_once", {31'b0, reg_file_wb_en}, 32'd0);

    // Store with wb_enable set: no register write
    resp_lat = 1;
    push_req(1'b1, 16'd0, 32'h1234);
    send(1'b1, 1'b0, 1'b1, 32'd1024, 32'h1234, 4'd9, f);
    check_val("t4_freeze_cycles", f, 32'd2);
    check_val("t4_wb_en", {31'b0, reg_file_wb_en}, 32'd0);

    // Timeout: memory never answers
    resp_lat = 0;
    check_val("t5_err_before", {31'b0, mem_error}, 32'd0);
    push_req(1'b0, 16'd4, 32'h0);
    push_wb(4'd7, 32'h0);
    send(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd7, f);
    check_val("t5_freeze_cycles", f, TMO + 1);
    check_val("t5_err_after", {31'b0, mem_error}, 32'd1);
    check_val("t5_wb_en", {31'b0, reg_file_wb_en}, 32'd1);
    check_val("t5_wb_data", reg_file_wb_data, 32'd0);

    // Back-to-back loads
    resp_lat = 1;
    push_req(1'b0, 16'd1, 32'h0);
    push_req(1'b0, 16'd3, 32'h0);
    rd_q.push_back(32'h1111_1111);
    rd_q.push_back(32'h3333_3333);
    push_wb(4'd1, 32'h1111_1111);
    push_wb(4'd2, 32'h3333_3333);
    send(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd1, f);
    check_val("t6a_freeze_cycles", f, 32'd2);
    send(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd2, f);
    check_val("t6b_freeze_cycles", f, 32'd2);
    repeat (4) @(posedge clk);
    #1;
    check_val("end_wb_pending", wb_q.size(), 32'd0);
    check_val("end_req_pending", req_q.size(), 32'd0);
    check_val("end_err_sticky", {31'b0, mem_error}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
